// File: rtl/eth_pkg.sv
// Shared types for the Ethernet frame arbiter: FIFO word layout and FSM states.
// FIFO words are {eop, sop, data}, so sop and eop sit directly above the payload.
package eth_pkg;

  localparam int DATA_W  = 64;
  localparam int WORD_W  = DATA_W + 2;
  localparam int SOP_BIT = DATA_W;
  localparam int EOP_BIT = DATA_W + 1;

  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    DISCARD = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first request at or after ptr_i.
// Returns the winner as both a one-hot vector and an index.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  int cand;

  // Scan from the farthest offset down so the nearest request is written last and wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (req_i[cand]) begin
        onehot_o       = '0;
        onehot_o[cand] = 1'b1;
        idx_o          = IW'(cand);
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_frame_arbiter.sv
// Frame-granular round-robin scheduler sharing one egress path between ingress FIFOs.
// Polices framing (stray words, missing EOP, overlong frames) behind a one-stage output register.
module eth_frame_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int CNT_W           = 16
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_PORTS-1:0]          fifo_empty,
  input  logic [NUM_PORTS*WORD_W-1:0]   fifo_rd_data,
  output logic [NUM_PORTS-1:0]          fifo_rd_en,
  output logic [DATA_W-1:0]             outData,
  output logic                          outSop,
  output logic                          outEop,
  output logic                          outErr,
  output logic                          outvld,
  input  logic                          out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [CNT_W-1:0]              frame_cnt,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int WC_W  = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAX_FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_sop_q, out_eop_q, out_err_q, out_vld_q;
  logic [CNT_W-1:0]   frame_cnt_q, drop_cnt_q;

  eth_word_t          head_w [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig, stale;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_head
      assign head_w[gi] = eth_word_t'(fifo_rd_data[gi*WORD_W +: WORD_W]);
      assign elig[gi]   = !fifo_empty[gi] &&  head_w[gi].sop;
      assign stale[gi]  = !fifo_empty[gi] && !head_w[gi].sop;
    end
  endgenerate

  // One picker serves both jobs: lowest stale port (pointer 0) takes precedence over the RR grant.
  logic                 any_stale;
  logic [NUM_PORTS-1:0] pick_req, pick_oh;
  logic [IDX_W-1:0]     pick_ptr, pick_idx;
  logic                 pick_any;

  assign any_stale = |stale;
  assign pick_req  = any_stale ? stale : elig;
  assign pick_ptr  = any_stale ? '0 : rr_ptr_q;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req_i    (pick_req),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  eth_word_t          gw;
  logic               g_empty;
  logic               can_load;
  logic [IDX_W-1:0]   rr_next;
  logic [WC_W-1:0]    wcnt_inc;

  assign gw       = head_w[grant_q];
  assign g_empty  = fifo_empty[grant_q];
  assign can_load = !out_vld_q || out_ready;
  assign rr_next  = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
  assign wcnt_inc = wcnt_q + WC_W'(1);

  logic [NUM_PORTS-1:0] rd_en;
  logic                 ld, ld_sop, ld_eop, ld_err;
  logic [DATA_W-1:0]    ld_data;
  logic                 frame_inc, drop_inc;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wcnt_d    = wcnt_q;
    rd_en     = '0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    ld_err    = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_stale) begin
          if (can_load) begin
            rd_en    = pick_oh;
            drop_inc = 1'b1;
          end
        end else if (pick_any) begin
          grant_d = pick_idx;
          wcnt_d  = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (can_load && !g_empty) begin
          if (wcnt_q != '0 && gw.sop) begin
            // Next frame arrived before our EOP: close this one with an error terminator.
            ld        = 1'b1;
            ld_eop    = 1'b1;
            ld_err    = 1'b1;
            frame_inc = 1'b1;
            rr_ptr_d  = rr_next;
            state_d   = IDLE;
          end else begin
            rd_en[grant_q] = 1'b1;
            ld             = 1'b1;
            ld_data        = gw.data;
            ld_sop         = (wcnt_q == '0);
            ld_eop         = gw.eop;
            wcnt_d         = wcnt_inc;
            if (gw.eop) begin
              frame_inc = 1'b1;
              rr_ptr_d  = rr_next;
              state_d   = IDLE;
            end else if (wcnt_inc == WC_MAX) begin
              ld_eop    = 1'b1;
              ld_err    = 1'b1;
              frame_inc = 1'b1;
              state_d   = DISCARD;
            end
          end
        end
      end

      DISCARD: begin
        if (!g_empty) begin
          if (gw.sop) begin
            state_d = IDLE;
          end else if (can_load) begin
            rd_en[grant_q] = 1'b1;
            drop_inc       = 1'b1;
            if (gw.eop) begin
              rr_ptr_d = rr_next;
              state_d  = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wcnt_q   <= wcnt_d;
      if (can_load) begin
        out_vld_q  <= ld;
        out_data_q <= ld_data;
        out_sop_q  <= ld_sop;
        out_eop_q  <= ld_eop;
        out_err_q  <= ld_err;
      end
      if (frame_inc) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (drop_inc && !(&drop_cnt_q)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pops are combinational, so hold them off while reset is asserted.
  assign fifo_rd_en = resetN ? '0 : rd_en;
  assign outData    = out_data_q;
  assign outSop     = out_sop_q;
  assign outEop     = out_eop_q;
  assign outErr     = out_err_q;
  assign outvld     = out_vld_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Self-checking bench: FIFOs are queues, a frame-level reference model predicts the egress stream.
// Directed scenarios first, then randomized contents with random backpressure.
module tb_eth_frame_arbiter;
  import eth_pkg::*;

  localparam int NP   = 4;
  localparam int MAXW = 8;
  localparam int CW   = 16;

  typedef struct packed {
    logic              err;
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } out_t;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic [NP-1:0]          fifo_empty;
  logic [NP*WORD_W-1:0]   fifo_rd_data;
  logic [NP-1:0]          fifo_rd_en;
  logic [DATA_W-1:0]      outData;
  logic                   outSop, outEop, outErr, outvld;
  logic                   out_ready;
  logic [$clog2(NP)-1:0]  grant_id;
  logic                   busy;
  logic [CW-1:0]          frame_cnt, drop_cnt;

  eth_frame_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .outData      (outData),
    .outSop       (outSop),
    .outEop       (outEop),
    .outErr       (outErr),
    .outvld       (outvld),
    .out_ready    (out_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] fq [NP][$];
  out_t got_q[$];
  out_t exp_q[$];
  int   exp_frames, exp_drops;
  int   n_pass, n_total;
  int   tick_no, first_vld, scn_start, ready_mode;
  bit   hold_pend;
  out_t held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p] = (fq[p].size() == 0);
      fifo_rd_data[p*WORD_W +: WORD_W] = (fq[p].size() > 0) ? fq[p][0] : '0;
    end
  endtask

  task automatic push_word(input int p, input bit sop, input bit eop, input logic [DATA_W-1:0] d);
    fq[p].push_back({eop, sop, d});
    refresh();
  endtask

  task automatic push_frame(input int p, input int len);
    for (int i = 0; i < len; i++)
      push_word(p, i == 0, i == len - 1, {$urandom, $urandom});
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int p = 0; p < NP; p++) if (fq[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Frame-level reference: walk the queued contents applying the arbitration and policing rules.
  task automatic run_model();
    logic [WORD_W-1:0] m [NP][$];
    logic [WORD_W-1:0] w;
    int rr, g, n, q;
    bit done, in_frame, disc;
    for (int p = 0; p < NP; p++) m[p] = fq[p];
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    rr   = 0;
    done = 1'b0;
    while (!done) begin
      g = -1;
      for (int p = 0; p < NP; p++)
        if (g < 0 && m[p].size() > 0 && !m[p][0][SOP_BIT]) g = p;
      if (g >= 0) begin
        void'(m[g].pop_front());
        exp_drops++;
      end else begin
        for (int k = 0; k < NP; k++) begin
          q = (rr + k) % NP;
          if (g < 0 && m[q].size() > 0 && m[q][0][SOP_BIT]) g = q;
        end
        if (g < 0) begin
          done = 1'b1;
        end else begin
          n = 0;
          in_frame = 1'b1;
          while (in_frame && m[g].size() > 0) begin
            w = m[g][0];
            if (n > 0 && w[SOP_BIT]) begin
              exp_q.push_back({1'b1, 1'b1, 1'b0, {DATA_W{1'b0}}});
              exp_frames++;
              rr = (g + 1) % NP;
              in_frame = 1'b0;
            end else begin
              void'(m[g].pop_front());
              n++;
              if (w[EOP_BIT]) begin
                exp_q.push_back({1'b0, 1'b1, n == 1, w[DATA_W-1:0]});
                exp_frames++;
                rr = (g + 1) % NP;
                in_frame = 1'b0;
              end else if (n == MAXW) begin
                exp_q.push_back({1'b1, 1'b1, n == 1, w[DATA_W-1:0]});
                exp_frames++;
                in_frame = 1'b0;
                disc = 1'b1;
                while (disc && m[g].size() > 0 && !m[g][0][SOP_BIT]) begin
                  w = m[g].pop_front();
                  exp_drops++;
                  if (w[EOP_BIT]) begin
                    rr = (g + 1) % NP;
                    disc = 1'b0;
                  end
                end
              end else begin
                exp_q.push_back({1'b0, 1'b0, n == 1, w[DATA_W-1:0]});
              end
            end
          end
          if (in_frame) done = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NP-1:0] rd;
    out_t cur;
    bit legal;
    @(negedge clk);
    tick_no++;
    rd  = fifo_rd_en;
    cur = {outErr, outEop, outSop, outData};
    if (hold_pend) check("hold_stable", 128'({outvld, cur}), 128'({1'b1, held}));
    legal = (rd == '0) ||
            ($onehot(rd) && ((rd & fifo_empty) == '0) && !(outvld && !out_ready));
    if (rd != '0 || (outvld && !out_ready)) check("pop_legal", 128'(legal), 128'(1));
    hold_pend = outvld && !out_ready;
    held      = cur;
    if (outvld && out_ready) got_q.push_back(cur);
    if (outvld && first_vld < 0) first_vld = tick_no;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (rd[p] && fq[p].size() > 0) void'(fq[p].pop_front());
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    refresh();
  endtask

  task automatic run_scn(input string name, input int budget);
    int cyc;
    int lim;
    run_model();
    got_q.delete();
    first_vld = -1;
    scn_start = tick_no;
    cyc = 0;
    while (cyc < budget && !(all_empty() && !busy && !outvld)) begin
      tick();
      cyc++;
    end
    check({name, "_timeout"}, 128'(cyc < budget), 128'(1));
    check({name, "_words"}, 128'(got_q.size()), 128'(exp_q.size()));
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("%s_w%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
    check({name, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_frames));
    check({name, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drops));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int p = 0; p < NP; p++) fq[p].delete();
    out_ready = 1'b1;
    hold_pend = 1'b0;
    refresh();
    @(posedge clk);
    #1;
    resetN = 1'b0;
  endtask

  task automatic gen_random(input int p);
    int nseg, typ, k;
    nseg = $urandom_range(1, 3);
    for (int s = 0; s < nseg; s++) begin
      typ = $urandom_range(0, 3);
      if (typ <= 1) begin
        push_frame(p, $urandom_range(1, 11));
      end else if (typ == 2) begin
        k = $urandom_range(0, 3);
        push_word(p, 1'b1, 1'b0, {$urandom, $urandom});
        for (int i = 0; i < k; i++) push_word(p, 1'b0, 1'b0, {$urandom, $urandom});
      end else begin
        k = $urandom_range(1, 2);
        for (int i = 0; i < k; i++) push_word(p, 1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
      end
    end
    push_frame(p, $urandom_range(1, 11));
  endtask

  logic [127:0] all_outs;
  assign all_outs = 128'({fifo_rd_en, outData, outSop, outEop, outErr, outvld,
                          grant_id, busy, frame_cnt, drop_cnt});

  initial begin
    n_pass = 0;
    n_total = 0;
    tick_no = 0;
    ready_mode = 0;
    hold_pend = 1'b0;
    out_ready = 1'b1;
    resetN = 1'b0;
    for (int p = 0; p < NP; p++) fq[p].delete();
    refresh();
    #1 resetN = 1'b1;
    #2 check("reset_outputs", all_outs, 128'(0));
    @(posedge clk);
    #1 resetN = 1'b0;

    // Single port, 4-word frame A0..A3, with pop-to-outvld latency.
    for (int i = 0; i < 4; i++) push_word(0, i == 0, i == 3, 64'hA0 + 64'(i));
    run_scn("single", 200);
    check("single_latency", 128'(first_vld - scn_start - 1), 128'(2));

    // Round robin: two 3-word frames on every port.
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) push_frame(p, 3);
    run_scn("rr", 400);

    // Backpressure: ready toggles every cycle during a 5-word frame.
    do_reset();
    ready_mode = 1;
    push_frame(0, 5);
    run_scn("bp", 200);
    ready_mode = 0;

    // Missing EOP on port 1 followed by a complete frame.
    do_reset();
    push_word(1, 1'b1, 1'b0, 64'hD0);
    push_word(1, 1'b0, 1'b0, 64'hD1);
    push_frame(1, 3);
    run_scn("noeop", 200);

    // Watchdog: 12-word frame on port 2, then a frame on port 3.
    do_reset();
    push_frame(2, 12);
    push_frame(3, 3);
    run_scn("wdog", 300);

    // Stale words on port 0.
    do_reset();
    for (int i = 0; i < 3; i++) push_word(0, 1'b0, 1'b0, {$urandom, $urandom});
    run_scn("stale", 100);

    // Randomized FIFO contents with random backpressure.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ready_mode = 2;
      for (int p = 0; p < NP; p++) gen_random(p);
      run_scn($sformatf("rand%0d", r), 3000);
    end
    ready_mode = 0;

    // Reset mid-frame: outputs clear at once, leftover words are flushed as stale.
    do_reset();
    push_frame(0, 6);
    repeat (4) tick();
    #2 resetN = 1'b1;
    #1 check("midreset_outputs", all_outs, 128'(0));
    @(posedge clk);
    #1 resetN = 1'b0;
    hold_pend = 1'b0;
    out_ready = 1'b1;
    run_scn("post_reset", 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_frame_arbiter.md
Name: eth_frame_arbiter

Overview:
Frame-granular round-robin scheduler that shares one egress send path between NUM_PORTS ingress frame FIFOs. FIFO words use the switch format {eop, sop, data[63:0]}. A port, once granted, keeps the grant until its EOP word is popped, so frames are never interleaved. The block also polices frame framing (stray words, missing EOP, overlong frames) and drives a registered egress stream with ready/valid backpressure.

Parameters:
NUM_PORTS, 4, number of ingress FIFOs (2..8)
DATA_W, 64, payload width; FIFO word width is DATA_W+2
MAX_FRAME_WORDS, 190, watchdog limit on words per frame, including SOP and EOP words
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  single clock; all logic is on the rising edge
resetN  in  1  asynchronous reset, ACTIVE-HIGH despite the name; 1 = reset
fifo_empty  in  NUM_PORTS  per-port FIFO empty flag
fifo_rd_data  in  NUM_PORTS*(DATA_W+2)  per-port head word; show-ahead, valid while !empty; port p occupies slice p
fifo_rd_en  out  NUM_PORTS  per-port pop strobe; at most one bit set per cycle; never set while that port is empty
outData  out  DATA_W  egress payload
outSop  out  1  egress start of frame
outEop  out  1  egress end of frame
outErr  out  1  qualifies an outEop word whose frame was truncated
outvld  out  1  egress word valid
out_ready  in  1  egress consumer accepts the word when outvld && out_ready
grant_id  out  $clog2(NUM_PORTS)  port currently granted; valid while busy
busy  out  1  high in XFER and DISCARD
frame_cnt  out  CNT_W  frames completed, wraps
drop_cnt  out  CNT_W  words discarded, saturates at all-ones

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; rr_ptr 0; word count 0; output register empty.
- Output register: a single stage. It loads when it is empty or being consumed (!outvld || out_ready). It holds its data and flags stable while outvld && !out_ready. A pop is allowed only in a cycle where the register can load, so latency from pop to outvld is 1 cycle.
- IDLE:
  - A port is eligible when it is non-empty and its head sop is 1.
  - A non-empty port with head sop 0 is stale. Pop the lowest-index stale port and increment drop_cnt. Stale flushing takes priority over granting, one pop per cycle.
  - Otherwise, if any port is eligible, grant the first eligible port at or after rr_ptr (circular). Latch grant_id and go to XFER. No pop happens in the grant cycle.
- XFER (granted port g):
  - Stall with no pop when fifo_empty[g] or the output register cannot load. outvld drops if the register has drained.
  - Word 0 is popped and forwarded with outSop 1. Word count becomes 1.
  - Subsequent words are popped and forwarded, and the count increments. Their sop is forced 0 on the output.
  - Popped word with eop 1: forward it, frame_cnt++, rr_ptr = (g+1) mod NUM_PORTS, go to IDLE.
  - Head with sop 1 after word 0 (missing EOP): do not pop it. Load a terminator word: data 0, outEop 1, outErr 1. Then frame_cnt++, advance rr_ptr, go to IDLE. The new frame is arbitrated normally.
  - Word count reaches MAX_FRAME_WORDS while the word being popped has no eop: forward it with outEop 1 and outErr 1, frame_cnt++, go to DISCARD.
- DISCARD: pop port g whenever it is non-empty, one word per cycle, incrementing drop_cnt per word. Nothing is emitted. When the popped word has eop 1, advance rr_ptr and go to IDLE. A head with sop 1 is not popped; go to IDLE.
- Simultaneous events:
  - An EOP pop and a new eligible port in the same cycle: the new grant happens the next cycle, so there is 1 idle arbitration cycle between frames.
  - out_ready low during an EOP pop: the EOP is held in the output register. The FSM may already grant, but it cannot pop until the register frees.
- Reset mid-frame: the output stream is cut with no EOP. FIFO contents are not touched by this block; stale words are flushed after reset.
- Counter widths: drop_cnt saturates; frame_cnt wraps modulo 2^CNT_W.

Decomposition:
- Package eth_pkg: DATA_W; typedef eth_word_t packed {eop, sop, data}; the SOP_BIT/EOP_BIT positions (64/65); the state enum {IDLE, XFER, DISCARD}.
- One sub-module, rr_pick: combinational round-robin selector (request vector, rr_ptr -> onehot, index, any).
- The output register stays inline.

Test Plan:
- Single port: port0 frame of 4 words (SOP 0xA0, 0xA1, 0xA2, EOP 0xA3), out_ready=1 -> outData A0..A3 on 4 consecutive cycles; outSop on A0 only, outEop on A3 only; frame_cnt=1; first outvld 2 cycles after the SOP is at the head.
- Round-robin fairness: ports 0-3 each hold two 3-word frames -> grant order 0,1,2,3,0,1,2,3; no interleaving; frame_cnt=8; rr_ptr=0 at the end.
- Backpressure: out_ready toggles 1010… during a 5-word frame -> each word is held stable while out_ready=0; no word is lost or duplicated; no fifo_rd_en while the register is full and not consumed.
- Missing EOP: port1 sends SOP, D1, then a new SOP frame -> output SOP, D1, then terminator (data 0, outEop=1, outErr=1); the new frame then follows complete; frame_cnt=2; drop_cnt=0.
- Watchdog: MAX_FRAME_WORDS=8, port2 frame of 12 words -> 8 words output, word 8 has outEop=1 and outErr=1; drop_cnt=4; the next frame on port3 is granted afterwards.
- Stale words and reset: port0 holds 3 words with sop=0 -> 3 pops, drop_cnt=3, nothing emitted. Assert resetN=1 mid-frame -> all outputs 0 immediately (asynchronous).
